// File: rtl/xalu_seq_if.sv
// xalu_seq_if : bus between the xalu_seq sequencer and one external,
// purely combinational 4-bit ALU slice.
//   master : sequencer side; drives operand nibbles, function code, complement
//            mode and both carry inputs; receives result nibble, carry outputs
//            and the per-nibble compare bit.
//   slave  : slice side; the mirror image of master.
interface xalu_seq_if;
   logic [3:0] sl_a;
   logic [3:0] sl_b;
   logic [2:0] sl_f;
   logic       sl_com;
   logic       sl_ci_right;
   logic       sl_ci_left;
   logic [3:0] sl_d;
   logic       sl_co_left;
   logic       sl_co_right;
   logic       sl_equ;

   modport master (
      output sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left,
      input  sl_d, sl_co_left, sl_co_right, sl_equ
   );

   modport slave (
      input  sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left,
      output sl_d, sl_co_left, sl_co_right, sl_equ
   );
endinterface

// File: rtl/xalu_seq.sv
// xalu_seq : drives one external 4-bit ALU slice serially, one nibble per
// cycle, to perform a NIBBLES x 4-bit operation.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   start               : request strobe, only looked at in IDLE
//   op, com, cin, a, b  : request (function code, complement mode,
//                         carry/fill in, operands); latched on acceptance
//   busy                : high for the NIBBLES RUN cycles
//   done                : one-cycle pulse, result and flags valid
//   result, cout, zero, equ : wide result and flags, held until next start
//   ovf                 : signed ADD overflow (only with XALU_SEQ_OVF_EN)
//   sl                  : slice bus (xalu_seq_if.master)
// Build option: define XALU_SEQ_OVF_EN to add the ovf output and its logic.
module xalu_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2:0]             op,
   input  logic                   com,
   input  logic                   cin,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   zero,
   output logic                   equ,
`ifdef XALU_SEQ_OVF_EN
   output logic                   ovf,
`endif
   xalu_seq_if.master             sl
);

   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES-1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [NIBBLES-1:0][3:0] a_q, b_q, res_q, res_nxt;
   logic [2:0]              op_q;
   logic                    com_q;
   logic                    carry_q, carry_nxt;
   logic                    equ_acc;
   logic [KW-1:0]           k_q;
   logic [KW-1:0]           n;
   logic                    last;
   logic                    chain_up, chain_dn;
   logic                    cout_q, zero_q, equ_q;
`ifdef XALU_SEQ_OVF_EN
   logic                    ovf_q;
`endif

   // ADD/SHL ripple carry LSB->MSB; SHR ripples the fill MSB->LSB.
   assign chain_up = (op_q == OP_ADD) || (op_q == OP_SHL);
   assign chain_dn = (op_q == OP_SHR);
   assign n        = chain_dn ? (K_LAST - k_q) : k_q;
   assign last     = (k_q == K_LAST);

   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign result = res_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
   assign equ    = equ_q;
`ifdef XALU_SEQ_OVF_EN
   assign ovf    = ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and slice-side drive; slice bus is all zero outside RUN
   always_comb begin
      state_nxt      = state;
      sl.sl_a        = '0;
      sl.sl_b        = '0;
      sl.sl_f        = '0;
      sl.sl_com      = 1'b0;
      sl.sl_ci_right = 1'b0;
      sl.sl_ci_left  = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            sl.sl_a        = a_q[n];
            sl.sl_b        = b_q[n];
            sl.sl_f        = op_q;
            sl.sl_com      = com_q;
            sl.sl_ci_right = chain_up & carry_q;
            sl.sl_ci_left  = chain_dn & carry_q;
            if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // result with the current slice nibble merged in, and the carry to keep
   always_comb begin
      res_nxt    = res_q;
      res_nxt[n] = sl.sl_d;
      carry_nxt  = carry_q;
      if (chain_up)      carry_nxt = sl.sl_co_left;
      else if (chain_dn) carry_nxt = sl.sl_co_right;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= '0;
         com_q   <= 1'b0;
         carry_q <= 1'b0;
         equ_acc <= 1'b0;
         k_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         equ_q   <= 1'b0;
`ifdef XALU_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               a_q     <= a;
               b_q     <= b;
               op_q    <= op;
               com_q   <= com;
               carry_q <= cin;
               equ_acc <= 1'b1;
               k_q     <= '0;
            end
            RUN: begin
               res_q   <= res_nxt;
               carry_q <= carry_nxt;
               equ_acc <= equ_acc & sl.sl_equ;
               k_q     <= k_q + 1'b1;
               // flags are captured on the closing edge so they are valid
               // throughout DONE and hold afterwards
               if (last) begin
                  cout_q <= (chain_up | chain_dn) & carry_nxt;
                  zero_q <= (res_nxt == '0);
                  equ_q  <= equ_acc & sl.sl_equ;
`ifdef XALU_SEQ_OVF_EN
                  ovf_q  <= (op_q == OP_ADD) && !com_q &&
                            (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                            (res_nxt[NIBBLES-1][3] != a_q[NIBBLES-1][3]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/xalu_seq.md
# xalu_seq

Multi-nibble operation sequencer that drives one external 4-bit ALU slice (`tt_um_kb2ghz_xalu`-style pinout) serially to perform NIBBLES×4-bit operations. It is the initiator side of the slice interface:
- accepts a wide operation request with a start/done handshake;
- presents one nibble per cycle to the slice with the function code and carry inputs;
- captures the slice outputs and chains carries between nibbles;
- assembles the wide result and status flags.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operation; legal values 2–8; W = 4·NIBBLES.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  function code; slice encoding: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- `com`  in  1  complement-output mode, passed to slice.
- `cin`  in  1  carry/fill in: ADD carry-in, SHL LSB fill, SHR MSB fill.
- `a`, `b`  in  W  operands.
- `busy`  out  1  high from the cycle after start acceptance through the last RUN cycle.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  W  assembled result; holds until the next accepted start.
- `cout`  out  1  final carry: ADD/SHL from the top slice `co_left`; SHR from the bottom slice `co_right`; 0 otherwise.
- `zero`  out  1  result == 0.
- `equ`  out  1  a == b, as the AND of all per-nibble slice `equ` outputs.
- `sl_a`, `sl_b`  out  4  slice operand nibbles.
- `sl_f`  out  3  slice function code.
- `sl_com`  out  1  slice complement mode.
- `sl_ci_right`, `sl_ci_left`  out  1  slice carry inputs.
- `sl_d`  in  4  slice result nibble.
- `sl_co_left`, `sl_co_right`, `sl_equ`  in  1  slice carry outputs and compare output.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - On `start`=1, latch `a`, `b`, `op`, `com`, `cin`.
  - Clear the nibble counter `k`.
  - Set the carry register to `cin` and the equ accumulator to 1.
  - Go to RUN.
- **RUN**: lasts exactly NIBBLES cycles. In each cycle:
  - Present nibble index n on `sl_a`/`sl_b`.
  - n = k, except for SHR, where n = NIBBLES-1-k (MSB-first).
  - At the clock edge, write `sl_d` into `result[4n+3:4n]`, update the carry register, AND `sl_equ` into the accumulator, and increment `k`.
- Carry routing:
  - ADD/SHL: `sl_ci_right` = carry register, `sl_ci_left` = 0, carry register ← `sl_co_left`.
  - SHR: `sl_ci_left` = carry register, `sl_ci_right` = 0, carry register ← `sl_co_right`.
  - AND/OR/XOR/PASSA/PASSB: both carry inputs 0; carry register not used.
- Leaving RUN: after `k` = NIBBLES-1, go to DONE.
- **DONE**
  - Assert `done`.
  - `cout` = carry register for ADD/SHL/SHR, 0 otherwise.
  - `zero` = (result == 0). With `com`=1, this is the complemented result.
  - `equ` = accumulator.
  - Return to IDLE.
- While in IDLE or DONE, the slice-side outputs are all 0 (`sl_f`=0).
- `start` during RUN or DONE is ignored and is not queued.
- Flags and `result` hold their last values in IDLE.

## Timing
- Reset values: state IDLE; `busy`, `done`, `result`, `cout`, `zero`, `equ` all 0; all slice-side outputs 0.
- Latency: start accepted at edge T; `busy`=1 for cycles T+1..T+NIBBLES; `done`=1 in cycle T+NIBBLES+1.
- Back-to-back: a new start is accepted in the cycle after DONE, so the minimum period is NIBBLES+2 cycles.
- The slice is combinational. `sl_d` and the slice carry/compare outputs are sampled at the edge closing the same cycle in which the nibble is presented.
- Reset asserted mid-RUN: abort immediately to IDLE; outputs return to reset values; no `done`.

## Configuration
- `XALU_SEQ_OVF_EN`
  - **Defined**: adds output `ovf` (1 bit, reset 0), valid in DONE.
    - For ADD with `com`=0: `ovf` = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]).
    - For all other cases: `ovf` = 0.
  - **Undefined**: no `ovf` port; no overflow logic.

## Test plan
All scenarios use NIBBLES=4.
- ADD a=0x1234, b=0x0FFF, cin=0 → result 0x2233, cout 0, zero 0; `busy` 4 cycles; `done` in cycle T+5.
- ADD a=0xFFFF, b=0x0001, cin=0 → result 0x0000, cout 1, zero 1. With OVF_EN: a=0x7FFF, b=0x0001 → ovf 1.
- SHL a=0x8001, cin=1 → result 0x0003, cout 1.
- SHR a=0x8001, cin=0 → result 0x4000, cout 1; `sl_a` sequence observed as 8, 0, 0, 1.
- XOR a=b=0xA5C3 → result 0x0000, zero 1, equ 1. PASSA a=0x00FF with com=1 → result 0xFF00, equ 0 (b≠a).
- Assert reset in the 2nd RUN cycle → all outputs 0 and no `done`. Pulse `start` during RUN of a prior op → ignored; exactly one `done`.
